// File: rtl/conf_pkg.sv
// Shared configuration for the acquisition-to-filter datapath: channel count,
// sample width, channel/data types and the streamer FSM state encoding.
package conf_pkg;

  localparam int CHANNEL_COUNT = 4;
  localparam int DATA_WIDTH    = 16;
  // One spare bit so out-of-range channel indices are representable and rejectable.
  localparam int CHANNEL_WIDTH = $clog2(CHANNEL_COUNT) + 1;
  localparam int STREAM_GAP    = 0;

  typedef logic [CHANNEL_WIDTH-1:0] channel_t;
  typedef logic [DATA_WIDTH-1:0]    data_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_WAIT = 2'd2
  } stream_state_t;

endpackage

// File: rtl/frame_bank_ram.sv
// Ping-pong frame storage: two banks of N_CH samples, one write port and one
// read port with a single registered read stage.
module frame_bank_ram
  import conf_pkg::*;
#(
  parameter int N_CH = CHANNEL_COUNT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_wr_en,
  input  logic                        i_wr_bank,
  input  logic [$clog2(N_CH)-1:0]     i_wr_ch,
  input  data_t                       i_wr_data,
  input  logic                        i_rd_en,
  input  logic                        i_rd_bank,
  input  logic [$clog2(N_CH)-1:0]     i_rd_ch,
  output data_t                       o_rd_data
);

  localparam int AW    = $clog2(N_CH);
  localparam int AAW   = AW + 1;
  localparam int DEPTH = 2 * N_CH;

  data_t            r_mem [DEPTH];
  data_t            r_rd_data;
  logic [AAW-1:0]   w_wr_addr;
  logic [AAW-1:0]   w_rd_addr;

  // Bank 1 occupies the upper N_CH words; linear so non-power-of-two N_CH packs tightly.
  assign w_wr_addr = i_wr_bank ? (AAW'(N_CH) + {1'b0, i_wr_ch}) : {1'b0, i_wr_ch};
  assign w_rd_addr = i_rd_bank ? (AAW'(N_CH) + {1'b0, i_rd_ch}) : {1'b0, i_rd_ch};

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[w_wr_addr] <= i_wr_data;
  end

  // The read register doubles as the output data register, so it holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[w_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/channel_frame_streamer.sv
// Streams a committed ping-pong frame as channel-interleaved beats (no backpressure).
// Optional STREAMER_ZERO_FILL_EN: unwritten channels of a frame are emitted as zero.
module channel_frame_streamer
  import conf_pkg::*;
#(
  parameter int N_CH = CHANNEL_COUNT,
  parameter int GAP  = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  input  channel_t wr_channel,
  input  data_t    wr_data,
  input  logic     wr_en,
  input  logic     frame_commit,
  output channel_t m_axis_a_tchannel,
  output data_t    m_axis_a_tdata,
  output logic     m_axis_a_tvalid,
  output logic     m_axis_a_tlast,
  output logic     busy,
  output logic     overflow
);

  localparam int            AW      = $clog2(N_CH);
  localparam int            GW      = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [AW-1:0] LAST_CH = AW'(N_CH - 1);

  stream_state_t  r_state;
  logic           r_wsel;
  logic [AW-1:0]  r_ch;
  logic [GW-1:0]  r_gap;
  logic           r_tvalid;
  logic           r_tlast;
  logic           r_overflow;
  channel_t       r_tchannel;

  logic           w_wr_ok;
  logic [AW-1:0]  w_wr_ch;
  logic           w_commit_ok;
  logic           w_rd_en;
  data_t          w_rd_data;

  assign w_wr_ok     = wr_en && (wr_channel < channel_t'(N_CH));
  assign w_wr_ch     = wr_channel[AW-1:0];
  assign w_commit_ok = frame_commit && (r_state == ST_IDLE);
  assign w_rd_en     = (r_state == ST_SCAN);

  // Write bank is r_wsel, read bank its complement; the swap happens on the commit edge.
  frame_bank_ram #(
    .N_CH (N_CH)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_ok),
    .i_wr_bank (r_wsel),
    .i_wr_ch   (w_wr_ch),
    .i_wr_data (wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_bank (~r_wsel),
    .i_rd_ch   (r_ch),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wsel     <= 1'b0;
      r_ch       <= '0;
      r_gap      <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_overflow <= 1'b0;
      r_tchannel <= '0;
    end else begin
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_overflow <= frame_commit && (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (frame_commit) begin
            r_wsel  <= ~r_wsel;
            r_ch    <= '0;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          r_tvalid   <= 1'b1;
          r_tchannel <= channel_t'(r_ch);
          r_tlast    <= (r_ch == LAST_CH);
          if (r_ch == LAST_CH) begin
            r_state <= ST_IDLE;
          end else if (GAP > 0) begin
            r_state <= ST_WAIT;
            r_gap   <= GW'(GAP);
          end else begin
            r_ch <= r_ch + AW'(1);
          end
        end
        ST_WAIT: begin
          if (r_gap == GW'(1)) begin
            r_state <= ST_SCAN;
            r_ch    <= r_ch + AW'(1);
          end else begin
            r_gap <= r_gap - GW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef STREAMER_ZERO_FILL_EN
  logic [N_CH-1:0] r_mask0;
  logic [N_CH-1:0] r_mask1;
  logic            r_fill;

  // The read bank's mask is never written during a scan, so it stays frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask0 <= '0;
      r_mask1 <= '0;
      r_fill  <= 1'b0;
    end else begin
      if (w_commit_ok) begin
        if (r_wsel) r_mask0 <= '0;
        else        r_mask1 <= '0;
      end
      if (w_wr_ok) begin
        if (r_wsel) r_mask1[w_wr_ch] <= 1'b1;
        else        r_mask0[w_wr_ch] <= 1'b1;
      end
      if (w_rd_en) r_fill <= r_wsel ? r_mask0[r_ch] : r_mask1[r_ch];
    end
  end

  assign m_axis_a_tdata = r_fill ? w_rd_data : '0;
`else
  assign m_axis_a_tdata = w_rd_data;
`endif

  assign m_axis_a_tchannel = r_tchannel;
  assign m_axis_a_tvalid   = r_tvalid;
  assign m_axis_a_tlast    = r_tlast;
  assign overflow          = r_overflow;
  assign busy              = (r_state != ST_IDLE) || r_tvalid;

endmodule

// File: tb/tb_channel_frame_streamer.sv
// Directed bench for channel_frame_streamer: one GAP=0 and one GAP=2 instance
// sharing the same write/commit stimulus.
module tb_channel_frame_streamer;
  import conf_pkg::*;

  localparam int MAXC = 16;

  logic     clk = 1'b0;
  logic     rst_n = 1'b1;
  channel_t wr_channel = '0;
  data_t    wr_data = '0;
  logic     wr_en = 1'b0;
  logic     frame_commit = 1'b0;

  channel_t o0_tch, o2_tch;
  data_t    o0_td, o2_td;
  logic     o0_tv, o0_tl, o0_busy, o0_ovf;
  logic     o2_tv, o2_tl, o2_busy, o2_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  logic     s_commit [MAXC];
  logic     s_wen    [MAXC];
  channel_t s_wch    [MAXC];
  data_t    s_wd     [MAXC];
  logic     s_rst    [MAXC];

  logic     c0_v [MAXC], c0_l [MAXC], c0_b [MAXC], c0_o [MAXC];
  channel_t c0_ch [MAXC];
  data_t    c0_d [MAXC];
  logic     c2_v [MAXC], c2_l [MAXC], c2_b [MAXC], c2_o [MAXC];
  channel_t c2_ch [MAXC];
  data_t    c2_d [MAXC];

  data_t ref_d [4];
  data_t exp_d [4];

  channel_frame_streamer #(.N_CH(4), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_channel(wr_channel), .wr_data(wr_data),
    .wr_en(wr_en), .frame_commit(frame_commit),
    .m_axis_a_tchannel(o0_tch), .m_axis_a_tdata(o0_td), .m_axis_a_tvalid(o0_tv),
    .m_axis_a_tlast(o0_tl), .busy(o0_busy), .overflow(o0_ovf)
  );

  channel_frame_streamer #(.N_CH(4), .GAP(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_channel(wr_channel), .wr_data(wr_data),
    .wr_en(wr_en), .frame_commit(frame_commit),
    .m_axis_a_tchannel(o2_tch), .m_axis_a_tdata(o2_td), .m_axis_a_tvalid(o2_tv),
    .m_axis_a_tlast(o2_tl), .busy(o2_busy), .overflow(o2_ovf)
  );

  always #5 clk = ~clk;

  task automatic clear_sched();
    for (int c = 0; c < MAXC; c++) begin
      s_commit[c] = 1'b0; s_wen[c] = 1'b0; s_wch[c] = '0; s_wd[c] = '0; s_rst[c] = 1'b0;
    end
  endtask

  // Cycle c is the interval after the c-th posedge; outputs are sampled at its negedge.
  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      rst_n        = ~s_rst[c];
      frame_commit = s_commit[c];
      wr_en        = s_wen[c];
      wr_channel   = s_wch[c];
      wr_data      = s_wd[c];
      @(negedge clk);
      c0_v[c] = o0_tv; c0_l[c] = o0_tl; c0_b[c] = o0_busy; c0_o[c] = o0_ovf;
      c0_ch[c] = o0_tch; c0_d[c] = o0_td;
      c2_v[c] = o2_tv; c2_l[c] = o2_tl; c2_b[c] = o2_busy; c2_o[c] = o2_ovf;
      c2_ch[c] = o2_tch; c2_d[c] = o2_td;
      @(posedge clk); #1;
    end
    rst_n = 1'b1; frame_commit = 1'b0; wr_en = 1'b0;
    clear_sched();
  endtask

  task automatic write_ch(input int ch, input int d);
    wr_en = 1'b1; wr_channel = channel_t'(ch); wr_data = data_t'(d);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic write_frame();
    for (int i = 0; i < 4; i++) write_ch(i, 10 * (i + 1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests += 12;
    if (o0_tv !== 1'b0)   begin n_fail++; $display("FAIL reset_tvalid0 got=%b exp=0", o0_tv); end
    if (o0_tl !== 1'b0)   begin n_fail++; $display("FAIL reset_tlast0 got=%b exp=0", o0_tl); end
    if (o0_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy0 got=%b exp=0", o0_busy); end
    if (o0_ovf !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf0 got=%b exp=0", o0_ovf); end
    if (o0_td !== '0)     begin n_fail++; $display("FAIL reset_tdata0 got=%0d exp=0", o0_td); end
    if (o0_tch !== '0)    begin n_fail++; $display("FAIL reset_tch0 got=%0d exp=0", o0_tch); end
    if (o2_tv !== 1'b0)   begin n_fail++; $display("FAIL reset_tvalid2 got=%b exp=0", o2_tv); end
    if (o2_tl !== 1'b0)   begin n_fail++; $display("FAIL reset_tlast2 got=%b exp=0", o2_tl); end
    if (o2_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy2 got=%b exp=0", o2_busy); end
    if (o2_ovf !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf2 got=%b exp=0", o2_ovf); end
    if (o2_td !== '0)     begin n_fail++; $display("FAIL reset_tdata2 got=%0d exp=0", o2_td); end
    if (o2_tch !== '0)    begin n_fail++; $display("FAIL reset_tch2 got=%0d exp=0", o2_tch); end
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_frame_gap0();
    logic ev, el, eb;
    write_frame();
    s_commit[0] = 1'b1;
    run_cycles(8);
    for (int c = 0; c < 8; c++) begin
      ev = (c >= 2 && c <= 5); el = (c == 5); eb = (c >= 1 && c <= 5);
      n_tests += 4;
      if (c0_v[c] !== ev) begin n_fail++; $display("FAIL gap0_tvalid c=%0d got=%b exp=%b", c, c0_v[c], ev); end
      if (c0_l[c] !== el) begin n_fail++; $display("FAIL gap0_tlast c=%0d got=%b exp=%b", c, c0_l[c], el); end
      if (c0_b[c] !== eb) begin n_fail++; $display("FAIL gap0_busy c=%0d got=%b exp=%b", c, c0_b[c], eb); end
      if (c0_o[c] !== 1'b0) begin n_fail++; $display("FAIL gap0_ovf c=%0d got=%b exp=0", c, c0_o[c]); end
      if (ev) begin
        n_tests += 2;
        if (c0_ch[c] !== channel_t'(c - 2))
          begin n_fail++; $display("FAIL gap0_tch c=%0d got=%0d exp=%0d", c, c0_ch[c], c - 2); end
        if (c0_d[c] !== ref_d[c - 2])
          begin n_fail++; $display("FAIL gap0_tdata c=%0d got=%0d exp=%0d", c, c0_d[c], ref_d[c - 2]); end
      end
    end
    idle(12);
  endtask

  task automatic test_gap();
    logic ev, el, eb;
    write_frame();
    s_commit[0] = 1'b1;
    run_cycles(14);
    for (int c = 0; c < 14; c++) begin
      ev = (c >= 2 && c <= 11 && ((c - 2) % 3) == 0); el = (c == 11); eb = (c >= 1 && c <= 11);
      n_tests += 4;
      if (c2_v[c] !== ev) begin n_fail++; $display("FAIL gap2_tvalid c=%0d got=%b exp=%b", c, c2_v[c], ev); end
      if (c2_l[c] !== el) begin n_fail++; $display("FAIL gap2_tlast c=%0d got=%b exp=%b", c, c2_l[c], el); end
      if (c2_b[c] !== eb) begin n_fail++; $display("FAIL gap2_busy c=%0d got=%b exp=%b", c, c2_b[c], eb); end
      if (c2_o[c] !== 1'b0) begin n_fail++; $display("FAIL gap2_ovf c=%0d got=%b exp=0", c, c2_o[c]); end
      if (c >= 2 && c <= 11) begin
        n_tests += 2;
        if (c2_ch[c] !== channel_t'((c - 2) / 3))
          begin n_fail++; $display("FAIL gap2_tch c=%0d got=%0d exp=%0d", c, c2_ch[c], (c - 2) / 3); end
        if (c2_d[c] !== ref_d[(c - 2) / 3])
          begin n_fail++; $display("FAIL gap2_tdata c=%0d got=%0d exp=%0d", c, c2_d[c], ref_d[(c - 2) / 3]); end
      end
    end
    idle(4);
  endtask

  task automatic test_overflow();
    logic ev, el, eb, eo, eo2;
    int k;
    write_frame();
    s_commit[0] = 1'b1; s_commit[3] = 1'b1; s_commit[5] = 1'b1;
    run_cycles(13);
    for (int c = 0; c < 13; c++) begin
      ev = (c >= 2 && c <= 5) || (c >= 7 && c <= 10);
      el = (c == 5) || (c == 10);
      eb = (c >= 1 && c <= 10);
      eo = (c == 4);
      eo2 = (c == 4) || (c == 6);
      k = (c <= 5) ? c - 2 : c - 7;
      n_tests += 5;
      if (c0_v[c] !== ev) begin n_fail++; $display("FAIL ovf_tvalid c=%0d got=%b exp=%b", c, c0_v[c], ev); end
      if (c0_l[c] !== el) begin n_fail++; $display("FAIL ovf_tlast c=%0d got=%b exp=%b", c, c0_l[c], el); end
      if (c0_b[c] !== eb) begin n_fail++; $display("FAIL ovf_busy c=%0d got=%b exp=%b", c, c0_b[c], eb); end
      if (c0_o[c] !== eo) begin n_fail++; $display("FAIL ovf_pulse0 c=%0d got=%b exp=%b", c, c0_o[c], eo); end
      if (c2_o[c] !== eo2) begin n_fail++; $display("FAIL ovf_pulse2 c=%0d got=%b exp=%b", c, c2_o[c], eo2); end
      if (ev) begin
        n_tests += 2;
        if (c0_ch[c] !== channel_t'(k))
          begin n_fail++; $display("FAIL ovf_tch c=%0d got=%0d exp=%0d", c, c0_ch[c], k); end
        if (c0_d[c] !== ref_d[k])
          begin n_fail++; $display("FAIL ovf_tdata c=%0d got=%0d exp=%0d", c, c0_d[c], ref_d[k]); end
      end
    end
    idle(4);
  endtask

  task automatic test_write_during_scan();
    logic ev, eb;
    int k;
`ifdef STREAMER_ZERO_FILL_EN
    exp_d[0] = 16'd0;  exp_d[1] = 16'd99; exp_d[2] = 16'd0;  exp_d[3] = 16'd77;
`else
    exp_d[0] = 16'd10; exp_d[1] = 16'd99; exp_d[2] = 16'd30; exp_d[3] = 16'd77;
`endif
    write_frame();
    s_commit[0] = 1'b1;
    s_wen[1] = 1'b1; s_wch[1] = channel_t'(1); s_wd[1] = data_t'(99);
    s_wen[2] = 1'b1; s_wch[2] = channel_t'(4); s_wd[2] = data_t'(55);
    s_commit[6] = 1'b1;
    s_wen[6] = 1'b1; s_wch[6] = channel_t'(3); s_wd[6] = data_t'(77);
    run_cycles(13);
    for (int c = 0; c < 13; c++) begin
      ev = (c >= 2 && c <= 5) || (c >= 8 && c <= 11);
      eb = (c >= 1 && c <= 5) || (c >= 7 && c <= 11);
      k = (c <= 5) ? c - 2 : c - 8;
      n_tests += 3;
      if (c0_v[c] !== ev) begin n_fail++; $display("FAIL wds_tvalid c=%0d got=%b exp=%b", c, c0_v[c], ev); end
      if (c0_b[c] !== eb) begin n_fail++; $display("FAIL wds_busy c=%0d got=%b exp=%b", c, c0_b[c], eb); end
      if (c0_o[c] !== 1'b0) begin n_fail++; $display("FAIL wds_ovf c=%0d got=%b exp=0", c, c0_o[c]); end
      if (ev) begin
        n_tests += 2;
        if (c0_ch[c] !== channel_t'(k))
          begin n_fail++; $display("FAIL wds_tch c=%0d got=%0d exp=%0d", c, c0_ch[c], k); end
        if (c <= 5) begin
          if (c0_d[c] !== ref_d[k])
            begin n_fail++; $display("FAIL wds_frame1 c=%0d got=%0d exp=%0d", c, c0_d[c], ref_d[k]); end
        end else begin
          if (c0_d[c] !== exp_d[k])
            begin n_fail++; $display("FAIL wds_frame2 c=%0d got=%0d exp=%0d", c, c0_d[c], exp_d[k]); end
        end
      end
    end
    idle(4);
  endtask

  task automatic test_reset_mid_scan();
    s_commit[0] = 1'b1;
    s_rst[3] = 1'b1;
    run_cycles(12);
    n_tests += 2;
    if (c0_v[2] !== 1'b1) begin n_fail++; $display("FAIL rms_first_beat got=%b exp=1", c0_v[2]); end
    if (c0_d[2] !== ref_d[0]) begin n_fail++; $display("FAIL rms_first_data got=%0d exp=%0d", c0_d[2], ref_d[0]); end
    n_tests += 4;
    if (c0_d[3] !== '0)  begin n_fail++; $display("FAIL rms_tdata0 got=%0d exp=0", c0_d[3]); end
    if (c0_ch[3] !== '0) begin n_fail++; $display("FAIL rms_tch0 got=%0d exp=0", c0_ch[3]); end
    if (c2_d[3] !== '0)  begin n_fail++; $display("FAIL rms_tdata2 got=%0d exp=0", c2_d[3]); end
    if (c2_b[3] !== 1'b0) begin n_fail++; $display("FAIL rms_busy2 got=%b exp=0", c2_b[3]); end
    for (int c = 3; c < 12; c++) begin
      n_tests += 5;
      if (c0_v[c] !== 1'b0) begin n_fail++; $display("FAIL rms_tvalid c=%0d got=%b exp=0", c, c0_v[c]); end
      if (c0_l[c] !== 1'b0) begin n_fail++; $display("FAIL rms_tlast c=%0d got=%b exp=0", c, c0_l[c]); end
      if (c0_b[c] !== 1'b0) begin n_fail++; $display("FAIL rms_busy c=%0d got=%b exp=0", c, c0_b[c]); end
      if (c0_o[c] !== 1'b0) begin n_fail++; $display("FAIL rms_ovf c=%0d got=%b exp=0", c, c0_o[c]); end
      if (c2_v[c] !== 1'b0) begin n_fail++; $display("FAIL rms_tvalid2 c=%0d got=%b exp=0", c, c2_v[c]); end
    end
    idle(2);
  endtask

  task automatic test_sparse_frame();
`ifdef STREAMER_ZERO_FILL_EN
    exp_d[0] = 16'd0;  exp_d[1] = 16'd0;  exp_d[2] = 16'd7; exp_d[3] = 16'd0;
`else
    exp_d[0] = 16'd10; exp_d[1] = 16'd20; exp_d[2] = 16'd7; exp_d[3] = 16'd40;
`endif
    write_ch(2, 7);
    s_commit[0] = 1'b1;
    run_cycles(7);
    for (int c = 2; c <= 5; c++) begin
      n_tests += 3;
      if (c0_v[c] !== 1'b1) begin n_fail++; $display("FAIL sparse_tvalid c=%0d got=%b exp=1", c, c0_v[c]); end
      if (c0_ch[c] !== channel_t'(c - 2))
        begin n_fail++; $display("FAIL sparse_tch c=%0d got=%0d exp=%0d", c, c0_ch[c], c - 2); end
      if (c0_d[c] !== exp_d[c - 2])
        begin n_fail++; $display("FAIL sparse_tdata c=%0d got=%0d exp=%0d", c, c0_d[c], exp_d[c - 2]); end
    end
    n_tests += 1;
    if (c0_v[6] !== 1'b0) begin n_fail++; $display("FAIL sparse_end got=%b exp=0", c0_v[6]); end
    idle(12);
  endtask

  initial begin
    ref_d[0] = 16'd10; ref_d[1] = 16'd20; ref_d[2] = 16'd30; ref_d[3] = 16'd40;
    clear_sched();
    test_reset();
    test_frame_gap0();
    test_gap();
    test_overflow();
    test_write_during_scan();
    test_reset_mid_scan();
    test_sparse_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
